pdp8_mem_sched: RTL

Memory scheduler and run controller for the bit-serial PDP-8 core. It owns a 128×12 word store that serves the CPU's bit-serial memory bus, and lets a host port load or inspect words while the CPU is halted. It also sequences `contin`, so the host can restart the CPU after a load. It sits between the `pdp8_cpu` pins (`ma`, `ba`, `write`, `mb`, `membus`, `halt`, `contin`) and a word-wide host/loader interface.

---
 rtl/pdp8_mem_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pdp8_mem_sched.sv
// pdp8_mem_sched: memory scheduler and run controller for the bit-serial
// PDP-8 core. Holds a 2^AW x WW word store that the CPU reads and writes one
// bit at a time, and lets a word-wide host port load or inspect words while
// the CPU is halted. It also sequences cpu_contin so the host can restart
// the CPU after a load.
//
// Ports:
//   sysclk, reset        clock; asynchronous active-high reset
//   cpu_ma, cpu_ba       CPU word address / bit address (0 = LSB)
//   cpu_write, cpu_mb    CPU bit-write strobe and serial write data
//   cpu_halt             CPU halted flag
//   cpu_membus           serial read data to the CPU (combinational)
//   cpu_contin           continue request to the CPU (registered)
//   host_req, host_we    host request (four-phase) and write/read select
//   host_addr/wdata      host word address and write word
//   host_run             host request to restart the CPU
//   host_ack             access done, held until host_req falls (registered)
//   host_rdata           last word read by the host (registered)
//   halted               CPU is stopped and the host owns the store (registered)
//
// Host handshake: a request is accepted only in HALT. The access happens at
// the edge that samples host_req=1; host_ack then rises and stays high until
// the edge that samples host_req=0. Because no access is made while ack is
// high, a held request is served exactly once.
module pdp8_mem_sched #(
  parameter int AW = 7,
  parameter int WW = 12
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ma,
  input  logic [3:0]    cpu_ba,
  input  logic          cpu_write,
  input  logic          cpu_mb,
  input  logic          cpu_halt,
  output logic          cpu_membus,
  output logic          cpu_contin,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [WW-1:0] host_wdata,
  input  logic          host_run,
  output logic          host_ack,
  output logic [WW-1:0] host_rdata,
  output logic          halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    HACC = 2'd2,
    CONT = 2'd3
  } state_t;

  localparam logic [4:0] WW_L = 5'(WW);

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] mem [2**AW];
  logic          ba_ok;
  logic          host_go;
  logic          cpu_wr_en;

  // Bit addresses past the top of the word neither read nor write.
  assign ba_ok = ({1'b0, cpu_ba} < WW_L);

  // Host access is taken only from HALT; the CPU may only write while it
  // owns the store (RUN, and CONT while it is still leaving its halt).
  assign host_go   = (state == HALT) && host_req;
  assign cpu_wr_en = ((state == RUN) || (state == CONT)) && cpu_write && ba_ok;

  assign cpu_membus = ba_ok ? mem[cpu_ma][cpu_ba] : 1'b0;

  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (cpu_halt) state_next = HALT;
      HALT: begin
        if (host_req)      state_next = HACC;
        else if (host_run) state_next = CONT;
      end
      HACC: if (!host_req) state_next = HALT;
      CONT: if (!cpu_halt) state_next = RUN;
      default: state_next = HALT;
    endcase
  end

  // State plus the flag outputs, registered from the next state so each
  // flag comes straight off a flop.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= HALT;
      halted     <= 1'b1;
      host_ack   <= 1'b0;
      cpu_contin <= 1'b0;
    end else begin
      state      <= state_next;
      halted     <= (state_next == HALT) || (state_next == HACC);
      host_ack   <= (state_next == HACC);
      cpu_contin <= (state_next == CONT);
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      host_rdata <= '0;
    end else if (host_go && !host_we) begin
      host_rdata <= mem[host_addr];
    end
  end

  // The store itself is not reset. Host and CPU writes are never enabled in
  // the same state, so at most one port writes on any edge.
  always_ff @(posedge sysclk) begin
    if (host_go && host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (cpu_wr_en) begin
      mem[cpu_ma][cpu_ba] <= cpu_mb;
    end
  end

endmodule
